mem8_ctrl_regs: RTL and testbench

//  Responder for the Xillybus mem_8 seekable interface: 5-bit address, 8-bit data.

---
 rtl/kc705_regs_pkg.sv | 36 +++
 rtl/mem8_cmd_seq.sv | 98 +++++++++
 rtl/mem8_ctrl_regs.sv | 130 +++++++++++++
 tb/tb_mem8_ctrl_regs.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/kc705_regs_pkg.sv
// Shared constants and types for the kc705 mem_8 control/status register block.
package kc705_regs_pkg;

    // Register map (5-bit address space)
    localparam logic [4:0] ADDR_ID       = 5'h00;
    localparam logic [4:0] ADDR_CMD      = 5'h01;
    localparam logic [4:0] ADDR_LED      = 5'h02;
    localparam logic [4:0] ADDR_STATUS   = 5'h03;
    localparam logic [4:0] ADDR_WRCNT    = 5'h04;
    localparam logic [4:0] ADDR_RSV_LO   = 5'h05;
    localparam logic [4:0] ADDR_RSV_HI   = 5'h07;
    localparam logic [4:0] ADDR_RAM_BASE = 5'h08;

    // Scratch RAM occupies 0x08..0x1F
    localparam int RAM_DEPTH = 24;

    // Command codes written to ADDR_CMD
    localparam logic [7:0] CMD_SOFT_RST = 8'h0F;
    localparam logic [7:0] CMD_CLEAR    = 8'hF0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } seq_state_t;

    // Largest of three cycle counts, used to size the sequencer counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mem8_cmd_seq.sv
// Command sequencer: soft-reset pulse with hold-off, and the RAM-clear walk.
module mem8_cmd_seq
    import kc705_regs_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_data,
    output logic       soft_rst_out,
    output logic       rst_busy,
    output logic       clr_busy,
    output logic [4:0] clr_idx
);

    localparam int CNT_MAX = max3(RST_CYCLES, HOLDOFF_CYCLES, RAM_DEPTH);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);
    localparam logic [CW-1:0] CLR_LAST  = CW'(RAM_DEPTH - 1);

    seq_state_t     state_r;
    logic [CW-1:0]  cnt_r;
    logic           soft_rst_r;

    // Sequencer state, cycle counter and registered soft-reset output.
    // soft_rst_r tracks the PULSE state exactly, so the pulse is RST_CYCLES wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            soft_rst_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_wr && (cmd_data == CMD_SOFT_RST)) begin
                        state_r    <= ST_PULSE;
                        cnt_r      <= RST_LOAD;
                        soft_rst_r <= 1'b1;
                    end else if (cmd_wr && (cmd_data == CMD_CLEAR)) begin
                        state_r    <= ST_CLEAR;
                        cnt_r      <= CNT_ZERO;
                        soft_rst_r <= 1'b0;
                    end else begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= CNT_ZERO;
                        soft_rst_r <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == CNT_ZERO) begin
                        soft_rst_r <= 1'b0;
                        if (HOLDOFF_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            state_r <= ST_HOLD;
                            cnt_r   <= HOLD_LOAD;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == CLR_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    soft_rst_r <= 1'b0;
                end
            endcase
        end
    end

    assign soft_rst_out = soft_rst_r;
    assign rst_busy     = (state_r == ST_PULSE) || (state_r == ST_HOLD);
    assign clr_busy     = (state_r == ST_CLEAR);
    assign clr_idx      = cnt_r[4:0];

endmodule

// File: rtl/mem8_ctrl_regs.sv
// Xillybus mem_8 target: control/status register map, scratch RAM and LED drive.
module mem8_ctrl_regs
    import kc705_regs_pkg::*;
#(
    parameter int         RST_CYCLES     = 16,
    parameter int         HOLDOFF_CYCLES = 8,
    parameter logic [7:0] ID_VALUE       = 8'hC5
) (
    input  logic       bus_clk,
    input  logic       rst_n,
    input  logic       user_w_mem_8_wren,
    input  logic [7:0] user_w_mem_8_data,
    input  logic [4:0] user_mem_8_addr,
    input  logic       user_r_mem_8_rden,
    output logic [7:0] user_r_mem_8_data,
    output logic       user_r_mem_8_empty,
    output logic       user_w_mem_8_full,
    input  logic [7:0] status_in,
    output logic [3:0] led_out,
    output logic       soft_rst_out
);

    logic [7:0] ram_r [RAM_DEPTH];
    logic [7:0] status_meta_r;
    logic [7:0] status_sync_r;
    logic [3:0] led_r;
    logic [7:0] wrcnt_r;
    logic [7:0] rdata_r;
    logic [7:0] rd_mux_s;

    logic       is_ram_s;
    logic       is_rsv_s;
    logic [4:0] ram_idx_s;
    logic       cmd_wr_s;
    logic       rst_busy_s;
    logic       clr_busy_s;
    logic [4:0] clr_idx_s;

    assign is_ram_s  = (user_mem_8_addr >= ADDR_RAM_BASE);
    assign is_rsv_s  = (user_mem_8_addr >= ADDR_RSV_LO) && (user_mem_8_addr <= ADDR_RSV_HI);
    assign ram_idx_s = user_mem_8_addr - ADDR_RAM_BASE;
    assign cmd_wr_s  = user_w_mem_8_wren && (user_mem_8_addr == ADDR_CMD);

    mem8_cmd_seq #(
        .RST_CYCLES     (RST_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_seq (
        .clk          (bus_clk),
        .rst_n        (rst_n),
        .cmd_wr       (cmd_wr_s),
        .cmd_data     (user_w_mem_8_data),
        .soft_rst_out (soft_rst_out),
        .rst_busy     (rst_busy_s),
        .clr_busy     (clr_busy_s),
        .clr_idx      (clr_idx_s)
    );

    // Two-flop synchroniser for the asynchronous status bits.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            status_meta_r <= 8'h00;
            status_sync_r <= 8'h00;
        end else begin
            status_meta_r <= status_in;
            status_sync_r <= status_meta_r;
        end
    end

    // LED register and write counter; reserved addresses are not counted.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r   <= 4'h0;
            wrcnt_r <= 8'h00;
        end else begin
            if (user_w_mem_8_wren && (user_mem_8_addr == ADDR_LED)) begin
                led_r <= user_w_mem_8_data[3:0];
            end
            if (user_w_mem_8_wren && !is_rsv_s) begin
                wrcnt_r <= wrcnt_r + 8'h01;
            end
        end
    end

    // Scratch RAM: the clear walk owns the write port while it runs.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_r[i] <= 8'h00;
            end
        end else if (clr_busy_s) begin
            ram_r[clr_idx_s] <= 8'h00;
        end else if (user_w_mem_8_wren && is_ram_s) begin
            ram_r[ram_idx_s] <= user_w_mem_8_data;
        end
    end

    // Read mux over the register map, using pre-write values.
    always_comb begin
        rd_mux_s = 8'h00;
        case (user_mem_8_addr)
            ADDR_ID:     rd_mux_s = ID_VALUE;
            ADDR_CMD:    rd_mux_s = {6'b000000, clr_busy_s, rst_busy_s};
            ADDR_LED:    rd_mux_s = {4'h0, led_r};
            ADDR_STATUS: rd_mux_s = status_sync_r;
            ADDR_WRCNT:  rd_mux_s = wrcnt_r;
            default: begin
                if (is_ram_s) begin
                    rd_mux_s = ram_r[ram_idx_s];
                end else begin
                    rd_mux_s = 8'h00;
                end
            end
        endcase
    end

    // Registered read data: updated on rden, held otherwise.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else if (user_r_mem_8_rden) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign user_r_mem_8_data  = rdata_r;
    assign led_out            = led_r;
    assign user_r_mem_8_empty = 1'b0;
    assign user_w_mem_8_full  = 1'b0;

endmodule

// File: tb/tb_mem8_ctrl_regs.sv
// Directed self-checking bench for mem8_ctrl_regs with an expected-read queue.
module tb_mem8_ctrl_regs;

    logic       bus_clk;
    logic       rst_n;
    logic       user_w_mem_8_wren;
    logic [7:0] user_w_mem_8_data;
    logic [4:0] user_mem_8_addr;
    logic       user_r_mem_8_rden;
    logic [7:0] user_r_mem_8_data;
    logic       user_r_mem_8_empty;
    logic       user_w_mem_8_full;
    logic [7:0] status_in;
    logic [3:0] led_out;
    logic       soft_rst_out;

    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    mem8_ctrl_regs dut (
        .bus_clk            (bus_clk),
        .rst_n              (rst_n),
        .user_w_mem_8_wren  (user_w_mem_8_wren),
        .user_w_mem_8_data  (user_w_mem_8_data),
        .user_mem_8_addr    (user_mem_8_addr),
        .user_r_mem_8_rden  (user_r_mem_8_rden),
        .user_r_mem_8_data  (user_r_mem_8_data),
        .user_r_mem_8_empty (user_r_mem_8_empty),
        .user_w_mem_8_full  (user_w_mem_8_full),
        .status_in          (status_in),
        .led_out            (led_out),
        .soft_rst_out       (soft_rst_out)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        user_mem_8_addr   = a;
        user_w_mem_8_data = d;
        user_w_mem_8_wren = 1'b1;
        @(negedge bus_clk);
        user_w_mem_8_wren = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] e);
        user_mem_8_addr   = a;
        user_r_mem_8_rden = 1'b1;
        exp_q.push_back(e);
        @(negedge bus_clk);
        user_r_mem_8_rden = 1'b0;
        chk(tag, user_r_mem_8_data, exp_q.pop_front());
    endtask

    initial begin
        rst_n             = 1'b0;
        user_w_mem_8_wren = 1'b0;
        user_w_mem_8_data = 8'h00;
        user_mem_8_addr   = 5'h00;
        user_r_mem_8_rden = 1'b0;
        status_in         = 8'h00;
        repeat (3) @(negedge bus_clk);
        rst_n = 1'b1;
        @(negedge bus_clk);

        // 1. reset state, ID and reserved read
        chk("rst_rdata", user_r_mem_8_data, 8'h00);
        chk("rst_led", {4'h0, led_out}, 8'h00);
        chk("rst_soft", {7'h00, soft_rst_out}, 8'h00);
        chk("tied_empty_full", {6'h00, user_r_mem_8_empty, user_w_mem_8_full}, 8'h00);
        rd("id", 5'h00, 8'hC5);
        // output holds while rden is low
        @(negedge bus_clk);
        chk("rdata_hold", user_r_mem_8_data, 8'hC5);
        rd("rsv_read", 5'h05, 8'h00);

        // 2. fill RAM, read back, write counter
        for (int i = 0; i < 24; i++) begin
            wr(5'(8 + i), 8'(8'h11 + i));
        end
        for (int i = 0; i < 24; i++) begin
            rd("ram_readback", 5'(8 + i), 8'(8'h11 + i));
        end
        rd("wrcnt_24", 5'h04, 8'd24);
        wr(5'h05, 8'h77);
        rd("rsv_write_ignored", 5'h05, 8'h00);
        rd("rsv_not_counted", 5'h04, 8'd24);
        // same-cycle read and write returns the old value
        user_mem_8_addr   = 5'h08;
        user_w_mem_8_data = 8'h99;
        user_w_mem_8_wren = 1'b1;
        user_r_mem_8_rden = 1'b1;
        exp_q.push_back(8'h11);
        @(negedge bus_clk);
        user_w_mem_8_wren = 1'b0;
        user_r_mem_8_rden = 1'b0;
        chk("rw_same_cycle_old", user_r_mem_8_data, exp_q.pop_front());
        rd("rw_same_cycle_new", 5'h08, 8'h99);

        // 3. soft reset pulse, hold-off, ignored re-trigger
        wr(5'h01, 8'h0F);
        for (int n = 0; n < 30; n++) begin
            chk("soft_rst_pulse", {7'h00, soft_rst_out}, (n <= 15) ? 8'h01 : 8'h00);
            if (n >= 1) begin
                chk("cmd_rst_busy", user_r_mem_8_data, exp_q.pop_front());
            end
            exp_q.push_back((n <= 23) ? 8'h01 : 8'h00);
            user_mem_8_addr   = 5'h01;
            user_r_mem_8_rden = 1'b1;
            user_w_mem_8_data = 8'h0F;
            user_w_mem_8_wren = (n == 5);
            @(negedge bus_clk);
        end
        user_r_mem_8_rden = 1'b0;
        user_w_mem_8_wren = 1'b0;
        chk("cmd_rst_busy", user_r_mem_8_data, exp_q.pop_front());
        rd("wrcnt_27", 5'h04, 8'd27);

        // 4. RAM clear with host writes dropped
        wr(5'h01, 8'hF0);
        wr(5'h10, 8'hAA);
        rd("cmd_clr_busy", 5'h01, 8'h02);
        wr(5'h08, 8'hBB);
        repeat (24) @(negedge bus_clk);
        rd("cmd_idle_after_clr", 5'h01, 8'h00);
        for (int i = 0; i < 24; i++) begin
            rd("ram_cleared", 5'(8 + i), 8'h00);
        end
        rd("wrcnt_30", 5'h04, 8'd30);

        // 5. LED, status synchroniser, async reset mid-pulse
        wr(5'h02, 8'hF5);
        chk("led_out", {4'h0, led_out}, 8'h05);
        rd("led_readback", 5'h02, 8'h05);
        status_in = 8'h3C;
        repeat (3) @(negedge bus_clk);
        rd("status_sync", 5'h03, 8'h3C);
        wr(5'h01, 8'h0F);
        repeat (3) @(negedge bus_clk);
        chk("soft_mid_pulse", {7'h00, soft_rst_out}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstn_soft_off", {7'h00, soft_rst_out}, 8'h00);
        chk("rstn_led_off", {4'h0, led_out}, 8'h00);
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(negedge bus_clk);
        rd("rstn_cmd_idle", 5'h01, 8'h00);
        rd("rstn_ram_zero", 5'h08, 8'h00);
        rd("rstn_wrcnt_zero", 5'h04, 8'h00);
        rd("rstn_led_zero", 5'h02, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
